// File: rtl/program_counter_unit_if.sv
// Control/status bundle between the control unit and the fetch-stage program counter.
// The control unit is the master; the program counter unit is the slave.
interface program_counter_unit_if #(
  parameter int N     = 16,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic          pc_enable;
  logic [2:0]    pc_op;
  logic [N-1:0]  pc_in;
  logic [N-1:0]  pc_out;
  logic [DW-1:0] stack_depth;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_error;

  modport master (
    output pc_enable, pc_op, pc_in,
    input  pc_out, stack_depth, stack_full, stack_empty, stack_error
  );

  modport slave (
    input  pc_enable, pc_op, pc_in,
    output pc_out, stack_depth, stack_full, stack_empty, stack_error
  );
endinterface

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter with increment, jump, relative branch, stall, and
// call/return backed by a DEPTH-entry return-address stack.
module program_counter_unit #(
  parameter int          N            = 16,
  parameter int          STEP         = 1,
  parameter int          DEPTH        = 4,
  parameter logic [N-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  program_counter_unit_if.slave pc_bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RETURN = 3'b101;

  logic [N-1:0]  pc;
  logic [N-1:0]  pc_next;
  logic [N-1:0]  pc_plus_step;
  logic [N-1:0]  ras [DEPTH];
  logic [DW-1:0] depth;
  logic [DW-1:0] depth_next;
  logic [DW-1:0] depth_m1;
  logic          err;
  logic          err_next;
  logic          full;
  logic          empty;
  logic          push;

  assign full         = (depth == DW'(DEPTH));
  assign empty        = (depth == '0);
  assign depth_m1     = depth - DW'(1);
  assign pc_plus_step = pc + N'(STEP);

  always_comb begin
    pc_next    = pc;
    depth_next = depth;
    err_next   = err;
    push       = 1'b0;
    if (pc_bus.pc_enable) begin
      case (pc_bus.pc_op)
        OP_INC:    pc_next = pc_plus_step;
        OP_JUMP:   pc_next = pc_bus.pc_in;
        // Two's-complement offset: modular addition gives the signed result directly.
        OP_BRANCH: pc_next = pc_plus_step + pc_bus.pc_in;
        OP_CALL: begin
          if (full) begin
            err_next = 1'b1;
          end else begin
            push       = 1'b1;
            depth_next = depth + DW'(1);
            pc_next    = pc_bus.pc_in;
          end
        end
        OP_RETURN: begin
          if (empty) begin
            err_next = 1'b1;
          end else begin
            depth_next = depth_m1;
            pc_next    = ras[depth_m1[AW-1:0]];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_VECTOR;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      pc    <= pc_next;
      depth <= depth_next;
      err   <= err_next;
    end
  end

  // Stack storage is not reset; only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (push) ras[depth[AW-1:0]] <= pc_plus_step;
  end

  assign pc_bus.pc_out      = pc;
  assign pc_bus.stack_depth = depth;
  assign pc_bus.stack_full  = full;
  assign pc_bus.stack_empty = empty;
  assign pc_bus.stack_error = err;

  logic unused_op_hold;
  assign unused_op_hold = ^OP_HOLD;
endmodule
